// File: rtl/evm_ballot_pkg.sv
// Shared types and defaults for the EVM voter-side ballot front end.
// WIDTH falls back to 8 when the project-wide `WIDTH define is absent.
`ifndef WIDTH
`define WIDTH 8
`endif

package evm_ballot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAST    = 2'd2,
    RELEASE = 2'd3
  } ballot_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    C1   = 2'd1,
    C2   = 2'd2,
    C3   = 2'd3
  } cand_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 1000;

  function automatic cand_e rise_to_cand(input logic [2:0] rise);
    case (rise)
      3'b001:  return C1;
      3'b010:  return C2;
      3'b100:  return C3;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [2:0] cand_to_onehot(input cand_e c);
    case (c)
      C1:      return 3'b001;
      C2:      return 3'b010;
      C3:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/evm_ballot_unit_debounce.sv
// One button channel: 2-flop synchronizer, stable-sample debouncer, and a
// registered rising-edge pulse on the debounced level.
module evm_debounce
  import evm_ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the level; agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// Ballot front end: conditions buttons and officer release, enforces one vote
// per release. Optional audit outputs are enabled by EVM_BALLOT_AUDIT_EN.
module evm_ballot_unit
  import evm_ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int WIDTH           = `WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch_on_evm,
  input  logic             officer_enable,
  input  logic             btn_candidate_1,
  input  logic             btn_candidate_2,
  input  logic             btn_candidate_3,
  output logic             vote_candidate_1,
  output logic             vote_candidate_2,
  output logic             vote_candidate_3,
  output logic             candidate_ready,
  output logic             ballot_armed,
  output logic             multi_press_err,
  output logic             timeout,
  output logic [WIDTH-1:0] ballots_cast,
  output ballot_state_e    dbg_state
`ifdef EVM_BALLOT_AUDIT_EN
  , output logic [1:0]       last_candidate
  , output logic [WIDTH-1:0] forfeited_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0] btn_raw, level, rise;
  logic [1:0] n_rise;

  assign btn_raw = {btn_candidate_3, btn_candidate_2, btn_candidate_1};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    evm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i  (clk),
      .rst_ni (rst),
      .raw_i  (btn_raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  // Officer release is level-synchronized and edge-detected, no debounce.
  logic off_s1_q, off_s2_q, off_prev_q, off_rise;
  assign off_rise = off_s2_q & ~off_prev_q;

  ballot_state_e    state_q, state_d;
  cand_e            cand_q, cand_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_d, tmo_pulse_d;
  logic [2:0]       vote_q;
  logic             ready_q, armed_q, err_q, tmo_pulse_q;
  logic [WIDTH-1:0] ballots_q;

  assign n_rise = 2'(rise[0]) + 2'(rise[1]) + 2'(rise[2]);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    tmo_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (off_rise && level == 3'b000) state_d = ARMED;
      end
      ARMED: begin
        tmo_d = tmo_q + TW'(1);
        // An edge is only clean if no other button is already held down.
        if (n_rise > 2'd1 || (n_rise == 2'd1 && (level & ~rise) != 3'b000)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (n_rise == 2'd1) begin
          cand_d  = rise_to_cand(rise);
          state_d = CAST;
        end else if (tmo_q == TMO_LAST) begin
          tmo_pulse_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CAST:    state_d = RELEASE;
      RELEASE: if (level == 3'b000) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!switch_on_evm) begin
      state_d     = IDLE;
      err_d       = 1'b0;
      tmo_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_s1_q    <= 1'b0;
      off_s2_q    <= 1'b0;
      off_prev_q  <= 1'b0;
      state_q     <= IDLE;
      cand_q      <= NONE;
      tmo_q       <= '0;
      vote_q      <= 3'b000;
      ready_q     <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
      ballots_q   <= '0;
    end else begin
      off_s1_q    <= officer_enable;
      off_s2_q    <= off_s1_q;
      off_prev_q  <= off_s2_q;
      state_q     <= state_d;
      cand_q      <= cand_d;
      tmo_q       <= tmo_d;
      vote_q      <= (state_d == CAST) ? cand_to_onehot(cand_d) : 3'b000;
      ready_q     <= (state_d == ARMED) || (state_d == CAST);
      armed_q     <= (state_d == ARMED);
      err_q       <= err_d;
      tmo_pulse_q <= tmo_pulse_d;
      if (state_d == CAST && ballots_q != '1) ballots_q <= ballots_q + WIDTH'(1);
    end
  end

  assign vote_candidate_1 = vote_q[0];
  assign vote_candidate_2 = vote_q[1];
  assign vote_candidate_3 = vote_q[2];
  assign candidate_ready  = ready_q;
  assign ballot_armed     = armed_q;
  assign multi_press_err  = err_q;
  assign timeout          = tmo_pulse_q;
  assign ballots_cast     = ballots_q;
  assign dbg_state        = state_q;

`ifdef EVM_BALLOT_AUDIT_EN
  logic [1:0]       last_q;
  logic [WIDTH-1:0] forfeit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= 2'd0;
      forfeit_q <= '0;
    end else begin
      if (state_d == CAST) last_q <= cand_d;
      if ((err_d || tmo_pulse_d) && forfeit_q != '1) forfeit_q <= forfeit_q + WIDTH'(1);
    end
  end

  assign last_candidate = last_q;
  assign forfeited_cnt  = forfeit_q;
`endif

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed and randomized bench for evm_ballot_unit (DEBOUNCE=4, TIMEOUT=20).
module tb_evm_ballot_unit;
  import evm_ballot_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int W   = 8;
  localparam int LAT = DEB + 4;   // sample index of the vote after the press is first driven
  localparam int SAT = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst, switch_on_evm, officer_enable;
  logic btn_candidate_1, btn_candidate_2, btn_candidate_3;
  logic vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic candidate_ready, ballot_armed, multi_press_err, timeout;
  logic [W-1:0] ballots_cast;
  ballot_state_e dbg_state;
`ifdef EVM_BALLOT_AUDIT_EN
  logic [1:0]   last_candidate;
  logic [W-1:0] forfeited_cnt;
`endif

  evm_ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .switch_on_evm    (switch_on_evm),
    .officer_enable   (officer_enable),
    .btn_candidate_1  (btn_candidate_1),
    .btn_candidate_2  (btn_candidate_2),
    .btn_candidate_3  (btn_candidate_3),
    .vote_candidate_1 (vote_candidate_1),
    .vote_candidate_2 (vote_candidate_2),
    .vote_candidate_3 (vote_candidate_3),
    .candidate_ready  (candidate_ready),
    .ballot_armed     (ballot_armed),
    .multi_press_err  (multi_press_err),
    .timeout          (timeout),
    .ballots_cast     (ballots_cast),
    .dbg_state        (dbg_state)
`ifdef EVM_BALLOT_AUDIT_EN
    , .last_candidate (last_candidate)
    , .forfeited_cnt  (forfeited_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  int model_cnt;
  int t, t_first, n_vote, n_err, n_to;
  logic to_armed;
  int pat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    t = 0; t_first = -1; n_vote = 0; n_err = 0; n_to = 0; to_armed = 1'bx;
  endtask

  task automatic sample();
    logic [2:0] v;
    v = {vote_candidate_3, vote_candidate_2, vote_candidate_1};
    if (v != 3'b000) begin
      n_vote++;
      if (t_first < 0) t_first = t;
      check("vote_onehot", 32'($onehot(v)), 32'd1);
      check("ready_in_cast", 32'(candidate_ready), 32'd1);
      if (exp_q.size() > 0) check("vote_candidate", 32'(v), 32'(exp_q.pop_front()));
      else                  check("spurious_vote", 32'(v), 32'd0);
    end
    if (multi_press_err) n_err++;
    if (timeout) begin
      n_to++;
      to_armed = ballot_armed;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
    sample();
  endtask

  // Driver tasks
  task automatic drive_btns(input logic [2:0] m);
    {btn_candidate_3, btn_candidate_2, btn_candidate_1} = m;
  endtask

  task automatic arm();
    officer_enable = 1'b1;
    tick(); tick();
    officer_enable = 1'b0;
    for (int i = 0; i < 10 && !ballot_armed; i++) tick();
    check("armed", 32'(ballot_armed), 32'd1);
  endtask

  // Plays pat[] on one button and checks the vote against the model: the vote
  // lands LAT samples after the start of the final unbroken run of presses.
  task automatic run_ballot(input logic [2:0] mask);
    int rs;
    rs = 0;
    for (int i = 0; i < pat.size(); i++)
      if (pat[i] == 1 && (i == 0 || pat[i-1] == 0)) rs = i;
    arm();
    clear_obs();
    exp_q.push_back(mask);
    foreach (pat[i]) begin
      drive_btns(pat[i] != 0 ? mask : 3'b000);
      tick();
    end
    drive_btns(3'b000);
    repeat (DEB + 6) tick();
    if (model_cnt < SAT) model_cnt++;
    check("vote_latency", 32'(t_first), 32'(rs + LAT));
    check("vote_count", 32'(n_vote), 32'd1);
    check("ballots_cast", 32'(ballots_cast), 32'(model_cnt));
    check("back_to_idle", 32'(dbg_state), 32'(IDLE));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; switch_on_evm = 1'b0; officer_enable = 1'b0;
    drive_btns(3'b000);
    model_cnt = 0;
    clear_obs();
    #2 rst = 1'b0;
    #1;
    check("reset_outputs", 32'({vote_candidate_1, vote_candidate_2, vote_candidate_3, candidate_ready,
                                ballot_armed, multi_press_err, timeout, ballots_cast}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1; switch_on_evm = 1'b1;
    repeat (3) tick();

    // Clean press on candidate 2 held 10 cycles
    pat.delete();
    repeat (10) pat.push_back(1);
    run_ballot(3'b010);

    // Candidate 1 bounces 1-0-1-1-0 then settles pressed
    pat = '{1, 0, 1, 1, 0};
    repeat (12) pat.push_back(1);
    run_ballot(3'b001);

    // Candidates 1 and 3 together forfeit the ballot
    arm();
    clear_obs();
    drive_btns(3'b101);
    repeat (8) tick();
    check("multi_err_pulse", 32'(n_err), 32'd1);
    check("multi_state_release", 32'(dbg_state), 32'(RELEASE));
    check("multi_no_armed", 32'(ballot_armed), 32'd0);
    drive_btns(3'b001);
    repeat (DEB + 6) tick();
    check("multi_hold_release", 32'(dbg_state), 32'(RELEASE));
    drive_btns(3'b000);
    repeat (DEB + 6) tick();
    check("multi_no_vote", 32'(n_vote), 32'd0);
    check("multi_ballots", 32'(ballots_cast), 32'(model_cnt));
    check("multi_idle", 32'(dbg_state), 32'(IDLE));

    // Armed ballot expires after TMO cycles
    arm();
    clear_obs();
    for (int i = 0; i < 100 && n_to == 0; i++) tick();
    check("timeout_cycles", 32'(t), 32'(TMO));
    check("timeout_pulse", 32'(n_to), 32'd1);
    check("timeout_armed_low", 32'(to_armed), 32'd0);
    drive_btns(3'b001);
    repeat (12) tick();
    drive_btns(3'b000);
    repeat (DEB + 6) tick();
    check("timeout_no_vote", 32'(n_vote), 32'd0);
    check("timeout_ballots", 32'(ballots_cast), 32'(model_cnt));

    // Held button plus a second officer pulse yields a single vote
    arm();
    clear_obs();
    exp_q.push_back(3'b100);
    drive_btns(3'b100);
    repeat (10) tick();
    officer_enable = 1'b1;
    tick(); tick();
    officer_enable = 1'b0;
    repeat (10) tick();
    if (model_cnt < SAT) model_cnt++;
    check("held_one_vote", 32'(n_vote), 32'd1);
    check("held_not_armed", 32'(ballot_armed), 32'd0);
    check("held_release", 32'(dbg_state), 32'(RELEASE));
    drive_btns(3'b000);
    repeat (DEB + 6) tick();
    check("held_idle", 32'(dbg_state), 32'(IDLE));
    check("held_no_rearm", 32'(ballot_armed), 32'd0);
    check("held_ballots", 32'(ballots_cast), 32'(model_cnt));

    // Power switch off while armed
    arm();
    switch_on_evm = 1'b0;
    tick();
    check("off_armed", 32'(ballot_armed), 32'd0);
    check("off_ready", 32'(candidate_ready), 32'd0);
    check("off_state", 32'(dbg_state), 32'(IDLE));
    check("off_ballots_held", 32'(ballots_cast), 32'(model_cnt));
    switch_on_evm = 1'b1;
    repeat (3) tick();

    // Reset asserted the cycle before CAST
    arm();
    clear_obs();
    drive_btns(3'b001);
    repeat (LAT - 1) tick();
    rst = 1'b0;
    #1;
    check("rst_outputs", 32'({vote_candidate_1, vote_candidate_2, vote_candidate_3, candidate_ready,
                              ballot_armed, multi_press_err, timeout, ballots_cast}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (5) tick();
    drive_btns(3'b000);
    rst = 1'b1;
    model_cnt = 0;
    repeat (DEB + 6) tick();
    check("rst_no_vote", 32'(n_vote), 32'd0);
    check("rst_ballots", 32'(ballots_cast), 32'd0);

    // Randomized ballots until saturation
    for (int n = 0; n < 300; n++) begin
      logic [2:0] m;
      int plen, hold;
      m = 3'b001 << $urandom_range(0, 2);
      plen = $urandom_range(0, 3);
      hold = DEB + $urandom_range(4, 8);
      pat.delete();
      repeat (plen) pat.push_back(int'($urandom_range(0, 1)));
      repeat (hold) pat.push_back(1);
      run_ballot(m);
    end
    check("saturated", 32'(ballots_cast), 32'(SAT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_ballot_unit.md
Name: evm_ballot_unit

Overview:
- Voter-side front end placed directly upstream of the EVM core.
- Conditions the three raw candidate push buttons and the presiding officer's ballot-release input.
- Enforces one ballot per release and drives the core's vote_candidate_1/2/3 and candidate_ready inputs with clean, single-cycle, mutually exclusive pulses.
- Keeps a running count of accepted ballots.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a debounced level changes (min 1).
- TIMEOUT_CYCLES, 1000: cycles an armed ballot may wait for a press before it is cancelled.
- WIDTH, 8: width of ballots_cast.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- switch_on_evm  in  1  machine power/enable; low forces IDLE.
- officer_enable  in  1  presiding officer release; rising edge arms one ballot.
- btn_candidate_1  in  1  raw asynchronous button, candidate 1.
- btn_candidate_2  in  1  raw asynchronous button, candidate 2.
- btn_candidate_3  in  1  raw asynchronous button, candidate 3.
- vote_candidate_1  out  1  one-cycle vote pulse to core.
- vote_candidate_2  out  1  one-cycle vote pulse to core.
- vote_candidate_3  out  1  one-cycle vote pulse to core.
- candidate_ready  out  1  high while a ballot is armed or being cast.
- ballot_armed  out  1  voter indicator lamp; high in ARMED only.
- multi_press_err  out  1  one-cycle pulse on an ambiguous press.
- timeout  out  1  one-cycle pulse when an armed ballot expires.
- ballots_cast  out  WIDTH  count of accepted votes, saturating.

Behaviour:
- Reset (rst=0): all outputs 0, FSM = IDLE, debouncers clear to 0, ballots_cast = 0. Assertion mid-operation aborts any ballot immediately; a pending vote pulse is never emitted.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any bounce restarts the count.
  - Rising-edge detect is applied on the debounced level. officer_enable is synchronized and edge-detected the same way, without debounce.
- FSM states: IDLE, ARMED, CAST, RELEASE.
  - IDLE → ARMED: officer_enable rising edge while switch_on_evm=1 and all debounced buttons low.
  - ARMED:
    - Exactly one debounced rising edge with the other two debounced levels low → CAST; latch the candidate.
    - Two or more edges in the same cycle, or an edge while another button is already debounced high → multi_press_err pulse, go to RELEASE, no vote, ballot forfeited.
    - TIMEOUT_CYCLES elapsed in ARMED → timeout pulse, go to IDLE.
  - CAST (exactly 1 cycle):
    - Drive the latched vote_candidate_N=1 with candidate_ready=1.
    - Increment ballots_cast, holding at 2^WIDTH-1.
    - Next state RELEASE.
  - RELEASE → IDLE: once all debounced buttons are low. A held button never produces a second vote.
- switch_on_evm=0 in any state → IDLE next cycle, no pulses. ballots_cast is held, not cleared.
- Outputs are registered. candidate_ready=1 in ARMED and CAST. vote_candidate_* are mutually exclusive and never high outside CAST.
- Latency: a clean press held from edge k gives a vote pulse visible after edge k+DEBOUNCE_CYCLES+3.
- officer_enable edges outside IDLE are ignored. A new ballot requires a fresh rising edge.

Optional Feature:
- Macro: EVM_BALLOT_AUDIT_EN.
- Defined:
  - Adds output last_candidate [1:0] (0 = none, 1..3 = candidate), updated in CAST and cleared only by rst.
  - Adds output forfeited_cnt [WIDTH-1:0], which counts multi_press_err and timeout events and saturates.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package evm_ballot_pkg holds:
  - Typedef ballot_state_e {IDLE, ARMED, CAST, RELEASE}.
  - Typedef cand_e [1:0] {NONE=0, C1=1, C2=2, C3=3}.
  - Default constants for DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
- WIDTH comes from the existing project-wide `WIDTH define.
- Sub-module evm_debounce (synchronizer, debounce counter, level out, rise pulse out) is instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Sequence: switch_on_evm=1, officer_enable pulse, btn_candidate_2 held 10 cycles → exactly one vote_candidate_2 pulse 7 cycles after press, with candidate_ready=1 in that cycle; ballots_cast 0→1; back to IDLE after release.
- Button 1 bouncing 1-0-1-1-0 (shorter than 4 stable samples), then stable → no vote during bounce; single pulse once stable for 4 samples.
- Buttons 1 and 3 pressed on the same cycle → multi_press_err pulse, no vote pulses, ballots_cast unchanged, RELEASE until both released.
- Armed with no press for 20 cycles → timeout pulse, ballot_armed falls, later press gives no vote.
- Button held through CAST plus a second officer_enable pulse → no second vote until release and a new officer_enable.
- rst=0 asserted in the cycle before CAST → no vote pulse, all outputs 0 asynchronously; ballots_cast saturates at 255 after 300 ballots (WIDTH=8).
